// File: rtl/accel_pkg.sv
// Definitions shared between the instruction queue and the controller:
// instruction width default, opcode field position and the opcode set.
package accel_pkg;

  localparam int unsigned INSTR_W_DEF = 64;
  localparam int unsigned OPC_W       = 4;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP   = 4'h0,
    OPC_LOAD  = 4'h1,
    OPC_STORE = 4'h2,
    OPC_MAC   = 4'h3,
    OPC_ACT   = 4'h4,
    OPC_SYNC  = 4'hF
  } opcode_e;

  localparam logic [OPC_W-1:0] NOP_OPCODE_DEF = OPC_NOP;

endpackage

// File: rtl/instr_queue_mem.sv
// Queue storage: one synchronous write port, one combinational read port, no reset.
module instr_queue_mem #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_queue.sv
// FWFT instruction buffer: pointers, occupancy count, watermark/full flags,
// optional NOP dropping, synchronous flush and sticky overflow flag.
module instr_queue
  import accel_pkg::*;
#(
  parameter int unsigned      INSTR_W    = INSTR_W_DEF,
  parameter int unsigned      DEPTH      = 16,
  parameter int unsigned      AF_THRESH  = 12,
  parameter bit               DROP_NOP   = 1'b0,
  parameter logic [OPC_W-1:0] NOP_OPCODE = NOP_OPCODE_DEF,
  localparam int unsigned     PW         = $clog2(DEPTH),
  localparam int unsigned     CW         = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  input  logic               clear_err,
  output logic               buffer_full,
  output logic               buffer_almost_full,
  output logic [CW-1:0]      count,
  output logic               overflow_err
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic push_acc, is_nop, wr_en, pop;

  assign buffer_full        = (count_q == CW'(DEPTH));
  assign buffer_almost_full = (count_q >= CW'(AF_THRESH));
  assign out_valid          = (count_q != '0);
  assign in_ready           = !buffer_full && !flush;
  assign count              = count_q;
  assign overflow_err       = ovf_q;

  // A dropped NOP still completes the handshake; it just never reaches storage.
  assign push_acc = in_valid && in_ready;
  assign is_nop   = DROP_NOP && (in_instr[INSTR_W-1 -: OPC_W] == NOP_OPCODE);
  assign wr_en    = push_acc && !is_nop;
  assign pop      = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (!wr_en && pop) count_d = count_q - CW'(1);
    end
    // Set has priority over clear when both occur in one cycle.
    if (in_valid && buffer_full && !flush) ovf_d = 1'b1;
    else if (clear_err)                    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  instr_queue_mem #(
    .W     (INSTR_W),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_instr),
    .raddr (rd_ptr_q),
    .rdata (out_instr)
  );

endmodule

// File: tb/tb_instr_queue.sv
// Two queues (plain and NOP-dropping) share one stimulus stream; each is checked
// every cycle against a queue-based model of the buffer behaviour.
module tb_instr_queue;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_instr = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clear_err = 1'b0;

  logic        o_in_ready [2];
  logic [63:0] o_instr    [2];
  logic        o_valid    [2];
  logic        o_full     [2];
  logic        o_af       [2];
  logic [4:0]  o_count    [2];
  logic        o_ovf      [2];

  logic [63:0] mq [2][$];
  logic        movf [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_queue #(.INSTR_W(64), .DEPTH(DEPTH), .AF_THRESH(AF), .DROP_NOP(1'b0), .NOP_OPCODE(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid), .in_ready(o_in_ready[0]),
    .out_instr(o_instr[0]), .out_valid(o_valid[0]), .out_ready(out_ready), .flush(flush),
    .clear_err(clear_err), .buffer_full(o_full[0]), .buffer_almost_full(o_af[0]),
    .count(o_count[0]), .overflow_err(o_ovf[0]));

  instr_queue #(.INSTR_W(64), .DEPTH(DEPTH), .AF_THRESH(AF), .DROP_NOP(1'b1), .NOP_OPCODE(4'h0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid), .in_ready(o_in_ready[1]),
    .out_instr(o_instr[1]), .out_valid(o_valid[1]), .out_ready(out_ready), .flush(flush),
    .clear_err(clear_err), .buffer_full(o_full[1]), .buffer_almost_full(o_af[1]),
    .count(o_count[1]), .overflow_err(o_ovf[1]));

  task automatic check(input string tag, input int m, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, m, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      int sz = mq[m].size();
      check({tag, ":count"}, m, 64'(o_count[m]), 64'(sz));
      check({tag, ":out_valid"}, m, 64'(o_valid[m]), 64'(sz != 0));
      check({tag, ":full"}, m, 64'(o_full[m]), 64'(sz == DEPTH));
      check({tag, ":almost_full"}, m, 64'(o_af[m]), 64'(sz >= AF));
      check({tag, ":in_ready"}, m, 64'(o_in_ready[m]), 64'((sz != DEPTH) && !flush));
      check({tag, ":overflow"}, m, 64'(o_ovf[m]), 64'(movf[m]));
      if (sz != 0) check({tag, ":out_instr"}, m, o_instr[m], mq[m][0]);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then compare.
  task automatic step(input string tag);
    for (int m = 0; m < 2; m++) begin
      int sz = mq[m].size();
      bit full = (sz == DEPTH);
      bit push = in_valid && !full && !flush;
      bit pop  = (sz != 0) && out_ready && !flush;
      bit drop = (m == 1) && (in_instr[63:60] == 4'h0);
      if (!rst_n) begin
        mq[m].delete();
        movf[m] = 1'b0;
      end else begin
        if (in_valid && full && !flush) movf[m] = 1'b1;
        else if (clear_err)             movf[m] = 1'b0;
        if (flush) mq[m].delete();
        else begin
          if (pop) void'(mq[m].pop_front());
          if (push && !drop) mq[m].push_back(in_instr);
        end
      end
    end
    @(posedge clk); #1;
    $display("step %-10s in_v=%0b in=%h out_r=%0b fl=%0b clr=%0b cnt=%0d/%0d",
             tag, in_valid, in_instr, out_ready, flush, clear_err, o_count[0], o_count[1]);
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [63:0] w, input bit r, input bit f, input bit c);
    in_valid = v; in_instr = w; out_ready = r; flush = f; clear_err = c;
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: w[63:60] = 4'h0;
      1: w[63:60] = 4'hA;
      2: w[63:60] = 4'hB;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    movf[0] = 1'b0; movf[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");

    // Fill with out_ready low, watch watermark and full flags
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 64'h1000 + 64'(i), 0, 0, 0);
      step("fill");
    end
    // Overflow attempts while full, flag must stick
    drive(1, 64'hDEAD, 0, 0, 0);
    step("ovf");
    step("ovf2");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("pop_hold");
    drive(0, 0, 1, 0, 1);
    step("clr");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 13; i++) step("drain");

    // Keep 8 resident and stream through across pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1, {4'hA, 44'd0, 16'h2000 + 16'(i)}, 0, 0, 0);
      step("pre8");
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, {4'hB, 28'd0, $urandom}, 1, 0, 0);
      step("stream");
    end

    // Drop to 5 entries, then flush with simultaneous push and pop
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("to5");
    drive(1, 64'hC000_0000_0000_0001, 1, 1, 0);
    step("flush");
    drive(1, 64'h7, 0, 0, 0);
    step("push7");
    drive(1, 64'hA000_0000_0000_0007, 0, 0, 0);
    step("pushA7");

    // NOP dropping sequence
    drive(0, 0, 0, 1, 0);
    step("flush2");
    drive(1, 64'hA000_0000_0000_00AA, 0, 0, 0); step("nopA");
    drive(1, 64'h0000_0000_0000_0011, 0, 0, 0); step("nop0");
    drive(1, 64'hB000_0000_0000_00BB, 0, 0, 0); step("nopB");
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("nopdrain");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0);
      step("rand");
    end

    // Build up traffic then assert reset asynchronously for 3 cycles
    for (int i = 0; i < 10; i++) begin
      drive(1, rand_word(), 0, 0, 0);
      step("pre_rst");
    end
    drive(1, 64'hDEAD, 0, 0, 0);
    #2; rst_n = 1'b0;
    mq[0].delete(); mq[1].delete(); movf[0] = 1'b0; movf[1] = 1'b0;
    #1;
    check_all("async_rst");
    for (int i = 0; i < 3; i++) step("in_rst");
    @(negedge clk); rst_n = 1'b1;
    drive(1, 64'hA000_0000_0000_0055, 0, 0, 0);
    step("after_rst");
    drive(0, 0, 1, 0, 0);
    step("after_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
